// File: rtl/bist_pkg.sv
// Shared definitions for the BIST pattern controller: FSM states, the
// 16-bit Galois polynomial mask, the default seed and the LFSR step function.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] POLY_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Right-shifting Galois step for x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_step(input logic [15:0] r);
        return (r >> 1) ^ (r[0] ? POLY_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit Galois shift register, used both as pattern generator (data_in=0)
// and as multiple-input signature register (data_in=core outputs).
module bist_lfsr16
    import bist_pkg::*;
#(
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic [15:0] data_in,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= lfsr_step(q) ^ data_in;
        end
    end

endmodule

// File: rtl/bist_pattern_ctrl.sv
// BIST controller: drives pseudo-random patterns into a core, compacts its
// outputs into a MISR and compares against a golden signature.
// Optional serial signature readout is built when BIST_SIG_SERIAL_EN is defined.
module bist_pattern_ctrl
    import bist_pkg::*;
#(
    parameter int unsigned PI_W       = 3,
    parameter int unsigned PO_W       = 6,
    parameter int unsigned LFSR_W     = 16,
    parameter int unsigned MISR_W     = 16,
    parameter int unsigned N_PATTERNS = 1024,
    parameter int unsigned DRAIN_CYC  = 2,
    parameter logic [15:0] LFSR_SEED  = DEFAULT_SEED,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [PI_W-1:0]   dut_pi,
    input  logic [PO_W-1:0]   dut_po,
    output logic [MISR_W-1:0] signature
`ifdef BIST_SIG_SERIAL_EN
    ,
    output logic              sig_so,
    output logic              sig_so_valid
`endif
);

    localparam int unsigned CNT_MAX = (N_PATTERNS > DRAIN_CYC) ? N_PATTERNS : DRAIN_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [LFSR_W-1:0]  lfsr;
    logic [MISR_W-1:0]  misr;
    logic [MISR_W-1:0]  misr_next;
    logic [MISR_W-1:0]  po_ext;
    logic               start_ok;
    logic               apply_last;
    logic               drain_last;

    assign po_ext     = MISR_W'(dut_po);
    assign misr_next  = lfsr_step(misr) ^ po_ext;
    assign start_ok   = start && ((state == IDLE) || (state == DONE));
    assign apply_last = (state == APPLY) && (cnt == CNT_W'(N_PATTERNS - 1));
    assign drain_last = (state == DRAIN) && (cnt == CNT_W'(DRAIN_CYC - 1));

    bist_lfsr16 #(.RST_VAL(LFSR_SEED)) u_prpg (
        .clk      (CK),
        .rst      (RST),
        .en       (state == APPLY),
        .load     (start_ok),
        .load_val (LFSR_SEED),
        .data_in  ('0),
        .q        (lfsr)
    );

    bist_lfsr16 #(.RST_VAL(16'h0000)) u_misr (
        .clk      (CK),
        .rst      (RST),
        .en       (busy),
        .load     (start_ok),
        .load_val ('0),
        .data_in  (po_ext),
        .q        (misr)
    );

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= APPLY;
                        cnt   <= '0;
                        pass  <= 1'b0;
                    end
                end
                APPLY: begin
                    if (apply_last) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_last) begin
                        state <= DONE;
                        cnt   <= '0;
                        // compare includes the final drain compaction
                        pass  <= (misr_next == GOLDEN_SIG);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state == APPLY) || (state == DRAIN);
    assign done      = (state == DONE);
    assign dut_pi    = (state == APPLY) ? lfsr[PI_W-1:0] : '0;
    assign signature = misr;

    // Only the low PI_W pattern bits reach the core
    logic unused_prpg_hi;
    assign unused_prpg_hi = ^lfsr[LFSR_W-1:PI_W];

`ifdef BIST_SIG_SERIAL_EN
    localparam int unsigned SCNT_W = $clog2(MISR_W + 1);

    logic [MISR_W-1:0] shadow;
    logic [SCNT_W-1:0] scnt;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            shadow <= '0;
            scnt   <= '0;
        end else if ((state == DONE) && start) begin
            scnt <= '0;
        end else if (drain_last) begin
            shadow <= misr_next;
            scnt   <= SCNT_W'(MISR_W);
        end else if (scnt != '0) begin
            shadow <= shadow >> 1;
            scnt   <= scnt - SCNT_W'(1);
        end
    end

    assign sig_so_valid = (scnt != '0);
    assign sig_so       = sig_so_valid & shadow[0];
`endif

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Self-checking bench for bist_pattern_ctrl against a cycle-level behavioural model.
module tb_bist_pattern_ctrl;

    localparam int          N    = 8;
    localparam int          D    = 2;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] GOLD = 16'h0000;

    logic        CK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  dut_po = '0;
    logic        busy, done, pass;
    logic [2:0]  dut_pi;
    logic [15:0] signature;
`ifdef BIST_SIG_SERIAL_EN
    logic        sig_so, sig_so_valid;
`endif

    always #5 CK = ~CK;

    bist_pattern_ctrl #(
        .PI_W       (3),
        .PO_W       (6),
        .N_PATTERNS (N),
        .DRAIN_CYC  (D),
        .LFSR_SEED  (SEED),
        .GOLDEN_SIG (GOLD)
    ) dut (
        .CK        (CK),
        .RST       (RST),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .dut_pi    (dut_pi),
        .dut_po    (dut_po),
        .signature (signature)
`ifdef BIST_SIG_SERIAL_EN
        ,
        .sig_so       (sig_so),
        .sig_so_valid (sig_so_valid)
`endif
    );

    int nchecks = 0;
    int nerrs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] r);
        logic [15:0] s;
        s = r >> 1;
        if (r[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    // Pattern k of a run is the seed advanced k times
    logic [15:0] pat [N];

    // Behavioural model: a run lasts N+D compacting cycles after the start edge
    bit          m_run  = 0;
    bit          m_done = 0;
    bit          m_pass = 0;
    int          m_cyc  = 0;
    logic [15:0] m_misr = '0;
    logic [15:0] m_ssig = '0;
    int          m_sidx = 16;

    always @(posedge CK or posedge RST) begin
        if (RST) begin
            m_run = 0; m_done = 0; m_pass = 0; m_cyc = 0; m_misr = '0; m_sidx = 16;
        end else if (m_run) begin
            m_misr = step(m_misr) ^ {10'b0, dut_po};
            m_cyc++;
            if (m_cyc == N + D) begin
                m_run = 0; m_done = 1; m_pass = (m_misr == GOLD);
                m_ssig = m_misr; m_sidx = 0;
            end
        end else begin
            if (m_done && m_sidx < 16) m_sidx++;
            if (start) begin
                m_run = 1; m_cyc = 0; m_misr = '0; m_done = 0; m_pass = 0; m_sidx = 16;
            end
        end
    end

    always @(negedge CK) begin
        logic [2:0] exp_pi;
        exp_pi = (m_run && m_cyc < N) ? pat[m_cyc][2:0] : 3'b000;
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("dut_pi", dut_pi, exp_pi);
        chk("signature", signature, m_misr);
        if (m_done) chk("pass", pass, m_pass);
`ifdef BIST_SIG_SERIAL_EN
        begin
            bit exp_v, exp_so;
            exp_v  = m_done && (m_sidx < 16);
            exp_so = exp_v ? m_ssig[m_sidx[3:0]] : 1'b0;
            chk("sig_so_valid", sig_so_valid, exp_v);
            chk("sig_so", sig_so, exp_so);
        end
`endif
    end

    task automatic tick();
        @(posedge CK);
        #2;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 60) begin
            tick();
            cyc++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        pat[0] = SEED;
        for (int i = 1; i < N; i++) pat[i] = step(pat[i-1]);
        chk("pat0", pat[0], 16'hACE1);
        chk("pat1", pat[1], 16'hE270);
        chk("pat2", pat[2], 16'h7138);

        #1 RST = 1'b1;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_pi", dut_pi, 3'b000);
        chk("rst_sig", signature, 16'h0000);
        tick(); tick();
        RST = 1'b0;
        tick();

        // first patterns after start
        pulse_start();
        chk("first_busy", busy, 1'b1);
        chk("first_pi0", dut_pi, 3'b001);
        tick();
        chk("first_pi1", dut_pi, 3'b000);
        tick();
        chk("first_pi2", dut_pi, 3'b000);
        wait_done(cyc);

        // zero-response run and start-to-done latency
        tick(); tick();
        pulse_start();
        wait_done(cyc);
        chk("zero_latency", cyc, 11);
        chk("zero_pass", pass, 1'b1);
        chk("zero_sig", signature, 16'h0000);
        repeat (20) tick();

        // single-bit error on the first applied pattern
        pulse_start();
        dut_po = 6'h01;
        tick();
        dut_po = 6'h00;
        wait_done(cyc);
        chk("err_sig", signature, 16'h00B4);
        chk("err_pass", pass, 1'b0);
        repeat (20) tick();

        // start while busy is ignored
        pulse_start();
        repeat (3) tick();
        pulse_start();
        cyc = 5;
        while (!done && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("busy_start_latency", cyc, 11);
        repeat (4) tick();

        // reset on the 5th applied pattern
        pulse_start();
        repeat (4) tick();
        RST = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_pi", dut_pi, 3'b000);
        chk("midrst_sig", signature, 16'h0000);
        chk("midrst_done", done, 1'b0);
        tick();
        RST = 1'b0;
        tick();
        pulse_start();
        chk("rerun_pi0", dut_pi, 3'b001);
        tick();
        chk("rerun_pi1", dut_pi, 3'b000);
        tick();
        chk("rerun_pi2", dut_pi, 3'b000);

        // randomized traffic: random responses, stray starts, rare resets
        for (int i = 0; i < 2000; i++) begin
            dut_po = 6'($urandom);
            start  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 299) == 0) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
